snake_body_engine: RTL



---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_next_head.sv | 71 +++++++
 rtl/snake_body_engine.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// ============================================================================
// snake_pkg : shared widths, directions and FSM encodings for the snake engine
// Rev 1.0
// ============================================================================
`default_nettype none

package snake_pkg;

   localparam int X_W = 10;
   localparam int Y_W = 9;

   localparam int DEF_STEP  = 10;
   localparam int DEF_X_MAX = 630;
   localparam int DEF_Y_MAX = 470;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_CHECK = 2'd1,
      S_DEAD  = 2'd2
   } state_t;

   // Opposite directions differ only in bit 1 with this encoding.
   function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
      return (a ^ b) == 2'd2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/snake_next_head.sv
// ============================================================================
// snake_next_head : combinational next-head calculator with wall handling
// Rev 1.0
// ============================================================================
`default_nettype none

module snake_next_head
   import snake_pkg::*;
#(
   parameter int STEP  = DEF_STEP,
   parameter int X_MAX = DEF_X_MAX,
   parameter int Y_MAX = DEF_Y_MAX,
   parameter bit WRAP  = 1'b0
) (
   input  logic [X_W-1:0] head_x,
   input  logic [Y_W-1:0] head_y,
   input  logic [1:0]     dir,
   output logic [X_W-1:0] next_x,
   output logic [Y_W-1:0] next_y,
   output logic           illegal
);

   localparam logic [X_W-1:0] STEP_X = X_W'(STEP);
   localparam logic [Y_W-1:0] STEP_Y = Y_W'(STEP);
   localparam logic [X_W-1:0] XMAX_V = X_W'(X_MAX);
   localparam logic [Y_W-1:0] YMAX_V = Y_W'(Y_MAX);

   // Walls are tested before the arithmetic so an underflowed value never leaves here.
   always_comb begin
      next_x  = head_x;
      next_y  = head_y;
      illegal = 1'b0;
      case (dir)
         DIR_UP: begin
            if (head_y < STEP_Y) begin
               if (WRAP) next_y = YMAX_V;
               else      illegal = 1'b1;
            end else begin
               next_y = head_y - STEP_Y;
            end
         end
         DIR_DOWN: begin
            if (head_y >= YMAX_V) begin
               if (WRAP) next_y = '0;
               else      illegal = 1'b1;
            end else begin
               next_y = head_y + STEP_Y;
            end
         end
         DIR_LEFT: begin
            if (head_x < STEP_X) begin
               if (WRAP) next_x = XMAX_V;
               else      illegal = 1'b1;
            end else begin
               next_x = head_x - STEP_X;
            end
         end
         DIR_RIGHT: begin
            if (head_x >= XMAX_V) begin
               if (WRAP) next_x = '0;
               else      illegal = 1'b1;
            end else begin
               next_x = head_x + STEP_X;
            end
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/snake_body_engine.sv
// ============================================================================
// snake_body_engine : snake body shift buffer, eat/collision detection, read port
// Define SNAKE_WRAP_EN to make wall moves wrap around instead of killing.
// Rev 1.0
// ============================================================================
`default_nettype none

module snake_body_engine
   import snake_pkg::*;
#(
   parameter int MAX_LEN  = 16,
   parameter int STEP     = DEF_STEP,
   parameter int START_X  = 320,
   parameter int START_Y  = 240,
   parameter int X_MAX    = DEF_X_MAX,
   parameter int Y_MAX    = DEF_Y_MAX,
   parameter int INIT_LEN = 3
) (
   input  logic                       CLOCK_50,
   input  logic                       reset,
   input  logic                       move_tick,
   input  logic [1:0]                 dir_req,
   input  logic [X_W-1:0]             foodX,
   input  logic [Y_W-1:0]             foodY,
   input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
   output logic [X_W-1:0]             snakeX,
   output logic [Y_W-1:0]             snakeY,
   output logic [$clog2(MAX_LEN):0]   length,
   output logic                       eat,
   output logic                       game_over,
   output logic [X_W-1:0]             rd_x,
   output logic [Y_W-1:0]             rd_y,
   output logic                       rd_valid
);

   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int LEN_W = IDX_W + 1;
   localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_RESET = LEN_W'(INIT_LEN);

`ifdef SNAKE_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   state_t               state, state_nxt;
   logic [1:0]           dir, dir_nxt, dir_try;
   logic [LEN_W-1:0]     len_nxt;
   logic                 eat_nxt, shift, illegal, food_hit, self_hit;
   logic [X_W-1:0]       seg_x [MAX_LEN];
   logic [Y_W-1:0]       seg_y [MAX_LEN];
   logic [X_W-1:0]       next_x;
   logic [Y_W-1:0]       next_y;
   logic [MAX_LEN-1:0]   hit_vec;

   assign dir_try   = is_reverse(dir_req, dir) ? dir : dir_req;
   assign snakeX    = seg_x[0];
   assign snakeY    = seg_y[0];
   assign game_over = (state == S_DEAD);
   assign food_hit  = (seg_x[0] == foodX) && (seg_y[0] == foodY);

   snake_next_head #(
      .STEP  (STEP),
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX),
      .WRAP  (WRAP)
   ) u_next_head (
      .head_x  (seg_x[0]),
      .head_y  (seg_y[0]),
      .dir     (dir_try),
      .next_x  (next_x),
      .next_y  (next_y),
      .illegal (illegal)
   );

   // Collision uses the length before any growth from this same check cycle.
   assign hit_vec[0] = 1'b0;
   for (genvar k = 1; k < MAX_LEN; k++) begin : g_hit
      assign hit_vec[k] = (LEN_W'(k) < length) &&
                          (seg_x[k] == seg_x[0]) && (seg_y[k] == seg_y[0]);
   end
   assign self_hit = |hit_vec;

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      len_nxt   = length;
      eat_nxt   = 1'b0;
      shift     = 1'b0;
      case (state)
         S_RUN: begin
            if (move_tick) begin
               dir_nxt = dir_try;
               if (illegal) begin
                  state_nxt = S_DEAD;
               end else begin
                  shift     = 1'b1;
                  state_nxt = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            state_nxt = S_RUN;
            if (food_hit) begin
               eat_nxt = 1'b1;
               if (length != LEN_FULL) len_nxt = length + 1'b1;
            end
            if (self_hit) state_nxt = S_DEAD;
         end
         S_DEAD: begin
            state_nxt = S_DEAD;
         end
         default: begin
            state_nxt = S_RUN;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state  <= S_RUN;
         dir    <= DIR_RIGHT;
         length <= LEN_RESET;
         eat    <= 1'b0;
      end else begin
         state  <= state_nxt;
         dir    <= dir_nxt;
         length <= len_nxt;
         eat    <= eat_nxt;
      end
   end

   // Full-depth shift: growing just exposes the old tail cell already held below.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= X_W'(START_X - i * STEP);
            seg_y[i] <= Y_W'(START_Y);
         end
      end else if (shift) begin
         seg_x[0] <= next_x;
         seg_y[0] <= next_y;
         for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         rd_x     <= '0;
         rd_y     <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_x     <= seg_x[rd_idx];
         rd_y     <= seg_y[rd_idx];
         rd_valid <= ({1'b0, rd_idx} < length);
      end
   end

endmodule

`default_nettype wire
